// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (CPU port C vs. debug port D).
package dm_arb_pkg;

    localparam int DM_AW = 4;
    localparam int DM_DW = 8;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG
    } owner_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the 16x8 data memory.
interface dm_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic          dbg_ready;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata
    );

    // Requesters and memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/dm_arb_aging_ctr.sv
// Saturating count of consecutive cycles the debug port was denied.
module dm_arb_aging_ctr #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign sat = (cnt_q == CW'(LIMIT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the data memory; CPU has default priority, debug is aged in.
// Optional exclusive debug access is compiled in with `define DM_ARB_LOCK_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW         = DM_AW,
    parameter int DW         = DM_DW,
    parameter int WAIT_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_arbiter_if.slave bus
);
    arb_state_t    state_q, state_d;
    owner_t        rd_owner_q;
    logic          gnt_c, gnt_d;
    logic          locked, sat;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wdata;
    logic          mux_we;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    assign locked = (state_q == LOCKED);

    // Grants are gated by rst_n so nothing is accepted or written while in reset.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (rst_n) begin
            if (locked) begin
                gnt_d = bus.dbg_req;
            end else begin
                gnt_d = bus.dbg_req & (~bus.cpu_req | sat);
                gnt_c = bus.cpu_req & ~gnt_d;
            end
        end
    end

    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (gnt_d) begin
            mux_we    = bus.dbg_we;
            mux_addr  = bus.dbg_addr;
            mux_wdata = bus.dbg_wdata;
        end else if (gnt_c) begin
            mux_we    = bus.cpu_we;
            mux_addr  = bus.cpu_addr;
            mux_wdata = bus.cpu_wdata;
        end
    end

    assign bus.dm_we     = mux_we;
    assign bus.dm_addr   = mux_addr;
    assign bus.dm_wdata  = mux_wdata;
    assign bus.cpu_ready = gnt_c;
    assign bus.dbg_ready = gnt_d;

    dm_arb_aging_ctr #(.LIMIT(WAIT_LIMIT)) u_aging (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.dbg_req & ~gnt_d),
        .clr   (gnt_d | ~bus.dbg_req | locked),
        .sat   (sat)
    );

    always_comb begin
        state_d = state_q;
`ifdef DM_ARB_LOCK_EN
        case (state_q)
            ARB:     if (gnt_d && bus.dbg_lock) state_d = LOCKED;
            LOCKED:  if (!bus.dbg_lock)         state_d = ARB;
            default: state_d = ARB;
        endcase
`else
        state_d = ARB;
`endif
    end

`ifndef DM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = bus.dbg_lock;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Read return: capture memory data for the reading owner; rvalid lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q  <= OWN_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (gnt_d && !bus.dbg_we) begin
                rd_owner_q  <= OWN_DBG;
                dbg_rdata_q <= bus.dm_rdata;
            end else if (gnt_c && !bus.cpu_we) begin
                rd_owner_q  <= OWN_CPU;
                cpu_rdata_q <= bus.dm_rdata;
            end else begin
                rd_owner_q  <= OWN_NONE;
            end
        end
    end

    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.dbg_rvalid = (rd_owner_q == OWN_DBG);
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 16x8 memory; honours DM_ARB_LOCK_EN.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(4), .DW(8)) bus ();

    dm_arbiter #(.AW(4), .DW(8), .WAIT_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory: combinational read, write at the edge; reloaded while reset is held.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
            mem[5] <= 8'hA7;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
        end
    end
    assign bus.dm_rdata = mem[bus.dm_addr];

`ifdef DM_ARB_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both masters requesting: nothing may be accepted or written.
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 4'd0;
        bus.cpu_wdata = 8'h00;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 4'd0;
        bus.dbg_wdata = 8'h00;
        bus.dbg_lock  = 1'b0;
        #2;
        check("rst_cpu_ready",  32'(bus.cpu_ready),  32'd0);
        check("rst_dbg_ready",  32'(bus.dbg_ready),  32'd0);
        check("rst_dm_we",      32'(bus.dm_we),      32'd0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'h00);
        check("rst_dbg_rdata",  32'(bus.dbg_rdata),  32'h00);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // CPU-only load of mem[5] = 0xA7.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'd5;
        @(negedge clk);
        check("c_only_ready",   32'(bus.cpu_ready), 32'd1);
        check("c_only_dready",  32'(bus.dbg_ready), 32'd0);
        check("c_only_dm_addr", 32'(bus.dm_addr),   32'd5);
        check("c_only_dm_we",   32'(bus.dm_we),     32'd0);
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("c_only_rvalid",   32'(bus.cpu_rvalid), 32'd1);
        check("c_only_rdata",    32'(bus.cpu_rdata),  32'hA7);
        check("c_only_d_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("idle_dm_addr",    32'(bus.dm_addr),    32'd0);
        next_cycle();
        @(negedge clk);
        check("c_only_rvalid_drop", 32'(bus.cpu_rvalid), 32'd0);
        check("c_only_rdata_hold",  32'(bus.cpu_rdata),  32'hA7);
        next_cycle();

        // Contention: both held high, grants C,C,C,D,C,C,C,D.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'd1;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 4'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("age_cpu_ready_%0d", i),  32'(bus.cpu_ready),  32'(i % 4 != 3));
            check($sformatf("age_dbg_ready_%0d", i),  32'(bus.dbg_ready),  32'(i % 4 == 3));
            check($sformatf("age_dbg_rvalid_%0d", i), 32'(bus.dbg_rvalid), 32'(i > 0 && i % 4 == 0));
            check($sformatf("age_cpu_rvalid_%0d", i), 32'(bus.cpu_rvalid), 32'(i > 0 && i % 4 != 0));
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("age_tail_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check("age_tail_dbg_rdata",  32'(bus.dbg_rdata),  32'h33);
        check("age_tail_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        next_cycle();

        // Debug writes 0x3C to addr 2, CPU reads it back next cycle.
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 4'd2;
        bus.dbg_wdata = 8'h3C;
        @(negedge clk);
        check("wr_dbg_ready",   32'(bus.dbg_ready), 32'd1);
        check("wr_dm_we",       32'(bus.dm_we),     32'd1);
        check("wr_dm_addr",     32'(bus.dm_addr),   32'd2);
        check("wr_dm_wdata",    32'(bus.dm_wdata),  32'h3C);
        next_cycle();
        bus.dbg_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'd2;
        @(negedge clk);
        check("rd_cpu_ready",      32'(bus.cpu_ready),  32'd1);
        check("rd_dm_we",          32'(bus.dm_we),      32'd0);
        check("wr_no_dbg_rvalid",  32'(bus.dbg_rvalid), 32'd0);
        next_cycle();
        // CPU stores 0x55 to addr 7 while its load data returns.
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 4'd7;
        bus.cpu_wdata = 8'h55;
        @(negedge clk);
        check("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("rd_cpu_rdata",  32'(bus.cpu_rdata),  32'h3C);
        check("cwr_dm_we",     32'(bus.dm_we),      32'd1);
        check("cwr_dm_addr",   32'(bus.dm_addr),    32'd7);
        check("cwr_dm_wdata",  32'(bus.dm_wdata),   32'h55);
        next_cycle();
        bus.cpu_req  = 1'b0;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 4'd7;
        @(negedge clk);
        check("cwr_no_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("drd_dbg_ready",     32'(bus.dbg_ready),  32'd1);
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("drd_dbg_rvalid",   32'(bus.dbg_rvalid), 32'd1);
        check("drd_dbg_rdata",    32'(bus.dbg_rdata),  32'h55);
        check("nogrant_dm_addr",  32'(bus.dm_addr),    32'd0);
        check("nogrant_dm_wdata", 32'(bus.dm_wdata),   32'd0);
        check("nogrant_dm_we",    32'(bus.dm_we),      32'd0);
        next_cycle();

        // Reset mid-read with the aging counter at 2.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'd5;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 4'd3;
        @(negedge clk);
        check("rr_cpu_ready_0", 32'(bus.cpu_ready), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rr_cpu_ready_1", 32'(bus.cpu_ready), 32'd1);
        next_cycle();
        check("rr_rvalid_pre", 32'(bus.cpu_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_rvalid_rst", 32'(bus.cpu_rvalid), 32'd0);
        check("rr_rdata_rst",  32'(bus.cpu_rdata),  32'h00);
        check("rr_dready_rst", 32'(bus.dbg_ready),  32'd0);
        check("rr_cready_rst", 32'(bus.cpu_ready),  32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rr_cpu_ready_%0d", i), 32'(bus.cpu_ready), 32'(i != 3));
            check($sformatf("rr_dbg_ready_%0d", i), 32'(bus.dbg_ready), 32'(i == 3));
            if (i == 0) check("rr_no_rvalid_after", 32'(bus.cpu_rvalid), 32'd0);
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        next_cycle();

        // Lock: debug grant with dbg_lock, then CPU requests for 4 cycles.
        bus.dbg_req  = 1'b1;
        bus.dbg_lock = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 4'd3;
        @(negedge clk);
        check("lk_dbg_ready", 32'(bus.dbg_ready), 32'd1);
        next_cycle();
        bus.dbg_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("lk_cpu_ready_%0d", i), 32'(bus.cpu_ready), 32'(!LOCK_BUILD));
            next_cycle();
        end
        bus.dbg_lock = 1'b0;
        @(negedge clk);
        check("lk_release_cycle", 32'(bus.cpu_ready), 32'(!LOCK_BUILD));
        next_cycle();
        @(negedge clk);
        check("lk_after_release", 32'(bus.cpu_ready), 32'd1);
        next_cycle();
        bus.cpu_req = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
